// File: rtl/idu_inst_queue_pkg.sv
// Shared definitions for the IDU instruction queue: default data width,
// RISC-V register-index field positions and the queue entry payload.
package idu_inst_queue_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_IDX_W    = 5;

    // Source register fields inside a 32-bit instruction word
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RS2_MSB = 24;

    // One queued instruction
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
        logic                    commit;
    } iq_entry_t;

endpackage

// File: rtl/idu_hazard_check.sv
// Load-use hazard detector for the instruction at the queue head.
// Ports:
//   head_present - a head instruction is being presented
//   inst         - head instruction word
//   load_valid   - EX stage holds a load
//   load_rd      - destination register of that load
//   stall_c      - head reads the register the load is still producing
module idu_hazard_check
    import idu_inst_queue_pkg::*;
(
    input  logic                    head_present,
    input  logic [XLEN_DEFAULT-1:0] inst,
    input  logic                    load_valid,
    input  logic [REG_IDX_W-1:0]    load_rd,
    output logic                    stall_c
);

    logic [REG_IDX_W-1:0] rs1_c;
    logic [REG_IDX_W-1:0] rs2_c;
    logic                 unused_inst_bits_c;

    // x0 is never a real dependency, so rd==0 never stalls
    always_comb begin
        rs1_c              = inst[RS1_MSB:RS1_LSB];
        rs2_c              = inst[RS2_MSB:RS2_LSB];
        unused_inst_bits_c = ^{inst[XLEN_DEFAULT-1:RS2_MSB+1], inst[RS1_LSB-1:0]};
        stall_c            = head_present && load_valid && (load_rd != '0) &&
                             ((load_rd == rs1_c) || (load_rd == rs2_c));
    end

endmodule

// File: rtl/idu_inst_queue.sv
// IDU instruction queue: circular FIFO between fetch and decode/EX with
// load-use hazard gating on the head entry.
// Optional feature: define IDU_QUEUE_BYPASS_EN to forward an incoming entry
// straight to the head outputs while the queue is empty.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   IDU_i_valid / IDU_o_ready       - upstream handshake
//   IDU_i_pc, IDU_i_inst, IDU_i_commit - upstream entry
//   IDU_i_flush                     - drop every queued entry
//   EXU_i_load_valid, EXU_i_load_rd - load currently in EX
//   IDU_o_valid / IDU_i_ready       - downstream handshake
//   IDU_o_pc, IDU_o_inst, IDU_o_commit - head entry
//   IDU_o_stall                     - head blocked by load-use hazard
//   IDU_o_count                     - occupancy
// XLEN must match the package entry width.
module idu_inst_queue
    import idu_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = XLEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IDU_i_valid,
    output logic                    IDU_o_ready,
    input  logic [XLEN-1:0]         IDU_i_pc,
    input  logic [XLEN-1:0]         IDU_i_inst,
    input  logic                    IDU_i_commit,
    input  logic                    IDU_i_flush,
    input  logic                    EXU_i_load_valid,
    input  logic [REG_IDX_W-1:0]    EXU_i_load_rd,
    output logic                    IDU_o_valid,
    input  logic                    IDU_i_ready,
    output logic [XLEN-1:0]         IDU_o_pc,
    output logic [XLEN-1:0]         IDU_o_inst,
    output logic                    IDU_o_commit,
    output logic                    IDU_o_stall,
    output logic [$clog2(DEPTH):0]  IDU_o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    iq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    iq_entry_t in_entry_c;
    iq_entry_t head_c;
    logic      empty_c;
    logic      full_c;
    logic      bypass_c;
    logic      head_present_c;
    logic      stall_c;
    logic      valid_c;
    logic      ready_c;
    logic      pop_c;
    logic      push_c;
    logic      wr_en_c;
    logic      rd_adv_c;

    // Incoming entry in package layout
    always_comb begin
        in_entry_c = '{pc:     XLEN_DEFAULT'(IDU_i_pc),
                       inst:   XLEN_DEFAULT'(IDU_i_inst),
                       commit: IDU_i_commit};
    end

    // Bypass is only possible when nothing older is queued
`ifdef IDU_QUEUE_BYPASS_EN
    assign bypass_c = empty_c && IDU_i_valid;
`else
    assign bypass_c = 1'b0;
`endif

    // Head selection: forwarded input or oldest stored entry
    always_comb begin
        empty_c        = (count == '0);
        full_c         = (count == CNT_W'(DEPTH));
        head_present_c = !empty_c || bypass_c;
        head_c         = bypass_c ? in_entry_c : mem[rd_ptr];
    end

    idu_hazard_check u_hazard (
        .head_present (head_present_c),
        .inst         (head_c.inst),
        .load_valid   (EXU_i_load_valid),
        .load_rd      (EXU_i_load_rd),
        .stall_c      (stall_c)
    );

    // Handshakes; a forwarded entry consumed this cycle is never stored
    always_comb begin
        valid_c  = head_present_c && !stall_c;
        pop_c    = valid_c && IDU_i_ready;
        ready_c  = !full_c || pop_c;
        push_c   = IDU_i_valid && ready_c;
        wr_en_c  = push_c && !(bypass_c && pop_c) && !IDU_i_flush;
        rd_adv_c = pop_c && !bypass_c && !IDU_i_flush;
    end

    // Pointer and occupancy state
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (IDU_i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_adv_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en_c, rd_adv_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en_c && !rst) begin
            mem[wr_ptr] <= in_entry_c;
        end
    end

    // Output drive
    always_comb begin
        IDU_o_ready  = ready_c;
        IDU_o_valid  = valid_c;
        IDU_o_stall  = stall_c;
        IDU_o_pc     = XLEN'(head_c.pc);
        IDU_o_inst   = XLEN'(head_c.inst);
        IDU_o_commit = head_c.commit;
        IDU_o_count  = count;
    end

endmodule

// File: tb/tb_idu_inst_queue.sv
// Bench for idu_inst_queue: directed scenarios on DEPTH=4 and randomized
// traffic on DEPTH=4/2/8, all checked against a queue-based reference model.
module tb_idu_inst_queue;

`ifdef IDU_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_v, vld_v, commit_v, flush_v, ldv_v, rdy_v;
    logic [2:0][31:0] pc_v, inst_v;
    logic [2:0][4:0]  ldrd_v;
    logic [2:0]       o_ready_v, o_valid_v, o_commit_v, o_stall_v;
    logic [2:0][31:0] o_pc_v, o_inst_v;
    logic [2:0][4:0]  cnt_v;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 4 : ((g == 1) ? 2 : 8);
        logic [$clog2(D):0] cnt;
        assign cnt_v[g] = 5'(cnt);
        idu_inst_queue #(.DEPTH(D), .XLEN(32)) u_dut (
            .clk              (clk),
            .rst              (rst_v[g]),
            .IDU_i_valid      (vld_v[g]),
            .IDU_o_ready      (o_ready_v[g]),
            .IDU_i_pc         (pc_v[g]),
            .IDU_i_inst       (inst_v[g]),
            .IDU_i_commit     (commit_v[g]),
            .IDU_i_flush      (flush_v[g]),
            .EXU_i_load_valid (ldv_v[g]),
            .EXU_i_load_rd    (ldrd_v[g]),
            .IDU_o_valid      (o_valid_v[g]),
            .IDU_i_ready      (rdy_v[g]),
            .IDU_o_pc         (o_pc_v[g]),
            .IDU_o_inst       (o_inst_v[g]),
            .IDU_o_commit     (o_commit_v[g]),
            .IDU_o_stall      (o_stall_v[g]),
            .IDU_o_count      (cnt)
        );
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        commit;
    } ent_t;

    ent_t        mq[$];
    int          sel;
    int unsigned mdepth;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        d_rst, d_vld, d_commit, d_flush, d_ldv, d_rdy;
    logic [31:0] d_pc, d_inst;
    logic [4:0]  d_ldrd;

    task automatic clr();
        d_rst = 0; d_vld = 0; d_commit = 0; d_flush = 0; d_ldv = 0; d_rdy = 0;
        d_pc = '0; d_inst = '0; d_ldrd = '0;
    endtask

    task automatic apply();
        for (int k = 0; k < 3; k++) begin
            rst_v[k]    = (k == sel) ? d_rst    : 1'b0;
            vld_v[k]    = (k == sel) ? d_vld    : 1'b0;
            commit_v[k] = d_commit;
            flush_v[k]  = (k == sel) ? d_flush  : 1'b0;
            ldv_v[k]    = (k == sel) ? d_ldv    : 1'b0;
            rdy_v[k]    = (k == sel) ? d_rdy    : 1'b0;
            pc_v[k]     = d_pc;
            inst_v[k]   = d_inst;
            ldrd_v[k]   = d_ldrd;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (inst %0d): observed %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    // Apply inputs and let outputs settle, for extra explicit checks
    task automatic peek();
        apply();
        #1;
    endtask

    // One clock: compare all outputs with the model, then advance the model
    task automatic step();
        int   sz;
        logic present, hz, ev, er, consumed;
        ent_t head, inc;
        apply();
        #1;
        sz      = mq.size();
        inc     = '{pc: d_pc, inst: d_inst, commit: d_commit};
        present = (sz > 0) || (BYP && d_vld);
        head    = (sz > 0) ? mq[0] : inc;
        hz      = present && d_ldv && (d_ldrd != 5'd0) &&
                  ((d_ldrd == head.inst[19:15]) || (d_ldrd == head.inst[24:20]));
        ev      = present && !hz;
        er      = (sz < int'(mdepth)) || (ev && d_rdy);
        check("valid", 64'(o_valid_v[sel]), 64'(ev));
        check("stall", 64'(o_stall_v[sel]), 64'(hz));
        check("ready", 64'(o_ready_v[sel]), 64'(er));
        check("count", 64'(cnt_v[sel]), 64'(sz));
        if (ev) begin
            check("pc", 64'(o_pc_v[sel]), 64'(head.pc));
            check("inst", 64'(o_inst_v[sel]), 64'(head.inst));
            check("commit", 64'(o_commit_v[sel]), 64'(head.commit));
        end
        if (d_rst || d_flush) begin
            mq.delete();
        end else begin
            consumed = ev && d_rdy;
            if (consumed && sz > 0) void'(mq.pop_front());
            if (d_vld && er && !(consumed && sz == 0)) mq.push_back(inc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Power-up reset of one instance; its outputs are unknown beforehand
    task automatic do_reset(input int k, input int unsigned depth);
        sel = k;
        mdepth = depth;
        clr();
        d_rst = 1;
        apply();
        @(posedge clk);
        @(negedge clk);
        mq.delete();
        d_rst = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic rdy);
        d_vld = 1; d_pc = pc; d_inst = 32'h0000_0013 ^ pc; d_commit = pc[2]; d_rdy = rdy;
        step();
        d_vld = 0; d_rdy = 0;
    endtask

    task automatic rand_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            d_vld    = ($urandom_range(0, 3) != 0);
            d_rdy    = ($urandom_range(0, 2) != 0);
            d_pc     = $urandom();
            d_inst   = $urandom();
            d_inst[19:15] = 5'($urandom_range(0, 7));
            d_inst[24:20] = 5'($urandom_range(0, 7));
            d_commit = 1'($urandom_range(0, 1));
            d_ldv    = ($urandom_range(0, 4) == 0);
            d_ldrd   = 5'($urandom_range(0, 7));
            d_flush  = ($urandom_range(0, 40) == 0);
            d_rst    = ($urandom_range(0, 150) == 0);
            step();
        end
        clr();
    endtask

    task automatic stream_and_drain(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            d_vld = 1; d_rdy = 1; d_pc = 32'h9000_0000 + 32'(c * 4);
            d_inst = $urandom(); d_commit = 1'(c);
            step();
        end
        clr();
        d_rdy = 1;
        for (int c = 0; c < int'(mdepth) + 2; c++) step();
        peek();
        check("drained_count", 64'(cnt_v[sel]), 64'd0);
        clr();
    endtask

    initial begin
        clr();
        sel = 0;
        mdepth = 4;
        apply();
        @(negedge clk);

        // ---- DEPTH=4 directed ----
        do_reset(0, 4);
        peek();
        check("rst_valid", 64'(o_valid_v[0]), 64'd0);
        check("rst_stall", 64'(o_stall_v[0]), 64'd0);
        check("rst_ready", 64'(o_ready_v[0]), 64'd1);
        check("rst_count", 64'(cnt_v[0]), 64'd0);
        step();

        // Fill with downstream blocked, then drain in order
        for (int i = 0; i < 4; i++) push(32'h8000_0000 + 32'(i * 4), 1'b0);
        peek();
        check("full_count", 64'(cnt_v[0]), 64'd4);
        check("full_ready", 64'(o_ready_v[0]), 64'd0);
        d_rdy = 1;
        for (int i = 0; i < 4; i++) step();
        d_rdy = 0;
        peek();
        check("drain_count", 64'(cnt_v[0]), 64'd0);

        // Push while full and popping: count holds, new entry emerges last
        for (int i = 0; i < 4; i++) push(32'h8000_0000 + 32'(i * 4), 1'b0);
        d_vld = 1; d_pc = 32'h8000_0010; d_inst = 32'h1234_5013; d_rdy = 1;
        peek();
        check("full_pushpop_ready", 64'(o_ready_v[0]), 64'd1);
        step();
        clr();
        peek();
        check("full_pushpop_count", 64'(cnt_v[0]), 64'd4);
        d_rdy = 1;
        for (int i = 0; i < 3; i++) step();
        peek();
        check("late_entry_pc", 64'(o_pc_v[0]), 64'h8000_0010);
        step();
        clr();

        // Load-use hazard on head (rs1=5, rs2=10)
        d_vld = 1; d_pc = 32'h8000_0020; d_inst = 32'h00A2_8533;
        step();
        clr();
        d_ldv = 1; d_ldrd = 5'd10; d_rdy = 1;
        peek();
        check("hz_rs2_stall", 64'(o_stall_v[0]), 64'd1);
        check("hz_rs2_valid", 64'(o_valid_v[0]), 64'd0);
        step();
        d_ldrd = 5'd5;
        step();
        d_ldrd = 5'd0;
        peek();
        check("hz_x0_stall", 64'(o_stall_v[0]), 64'd0);
        check("hz_x0_valid", 64'(o_valid_v[0]), 64'd1);
        step();
        clr();

        // Flush with a simultaneous push
        for (int i = 0; i < 3; i++) push(32'h8000_0030 + 32'(i * 4), 1'b0);
        d_flush = 1; d_vld = 1; d_pc = 32'h8000_0040;
        step();
        clr();
        peek();
        check("flush_count", 64'(cnt_v[0]), 64'd0);
        check("flush_valid", 64'(o_valid_v[0]), 64'd0);
        step();

        // Empty-queue push with downstream ready: bypass vs one-cycle latency
        d_vld = 1; d_pc = 32'h8000_0100; d_inst = 32'h0000_0013; d_rdy = 1;
        peek();
        check("empty_push_valid", 64'(o_valid_v[0]), BYP ? 64'd1 : 64'd0);
        check("empty_push_count", 64'(cnt_v[0]), 64'd0);
        step();
        d_vld = 0;
        peek();
        check("empty_push_next_valid", 64'(o_valid_v[0]), BYP ? 64'd0 : 64'd1);
        step();
        clr();

        // Reset mid-stream overrides push and pop
        for (int i = 0; i < 2; i++) push(32'h8000_0200 + 32'(i * 4), 1'b0);
        d_rst = 1; d_vld = 1; d_rdy = 1; d_pc = 32'h8000_0300;
        step();
        clr();
        peek();
        check("midrst_count", 64'(cnt_v[0]), 64'd0);
        check("midrst_ready", 64'(o_ready_v[0]), 64'd1);
        step();

        rand_phase(200);
        stream_and_drain(20);

        // ---- DEPTH=2 and DEPTH=8 wrap and random traffic ----
        do_reset(1, 2);
        stream_and_drain(20);
        rand_phase(200);
        stream_and_drain(20);

        do_reset(2, 8);
        for (int i = 0; i < 8; i++) push(32'hA000_0000 + 32'(i * 4), 1'b0);
        stream_and_drain(20);
        rand_phase(200);
        stream_and_drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
